// File: rtl/core_ctrl_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_wb_arb_pkg
// Shared constants for the core writeback path: requester indices, default
// requester count, data width, GPR index width and a helper that sizes the
// round-robin pointer.
// ---------------------------------------------------------------------------
package core_ctrl_wb_arb_pkg;

  // Requester slots on the writeback arbiter
  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_LSU = 1;
  localparam int WB_REQ_MDU = 2;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;
  localparam int RD_W    = 5;

  // Pointer width; a single requester still gets a 1-bit pointer so that
  // no zero-width vectors appear.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_rr_arbiter.sv
// ---------------------------------------------------------------------------
// core_rr_arbiter
// Rotating-priority arbiter. The requester named by ptr has the highest
// priority and priority descends cyclically from it. With ptr tied to zero it
// degenerates into a fixed lowest-index-wins arbiter.
//
// Ports:
//   req  [N-1:0]  request vector
//   ptr  [PW-1:0] highest-priority requester index (must be < N)
//   en            grant enable; gnt is all-zero when low
//   gnt  [N-1:0]  one-hot grant (all-zero if no request or en low)
// ---------------------------------------------------------------------------
module core_rr_arbiter
  import core_ctrl_wb_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_pick;
  logic [2*N-1:0] w_gnt2;

  // Rotate the request vector right by ptr so that bit 0 is the current
  // highest-priority requester, pick the lowest set bit, then rotate the
  // one-hot result back left by ptr.
  assign w_rot  = N'({req, req} >> ptr);
  assign w_pick = w_rot & (~w_rot + N'(1));
  assign w_gnt2 = {{N{1'b0}}, w_pick} << ptr;
  assign gnt    = en ? (w_gnt2[N-1:0] | w_gnt2[2*N-1:N]) : '0;

endmodule

// File: rtl/core_ctrl_wb_arb.sv
// ---------------------------------------------------------------------------
// core_ctrl_wb_arb
// Writeback arbiter for the core: NUM_REQ execution units compete for a
// single registered writeback slot. The slot accepts a new entry whenever it
// is empty or being drained (wb_stall low); a stalled entry is held.
//
// Configuration macro: CORE_WB_ARB_RR_EN
//   defined   -> round-robin arbitration with a rotating pointer
//   undefined -> fixed priority, lowest requester index wins
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_vld    [NUM_REQ]       per-requester writeback request
//   req_rd_idx [5*NUM_REQ]     per-requester destination GPR
//   req_data   [XLEN*NUM_REQ]  per-requester result
//   req_rdy    [NUM_REQ]       per-requester grant (at most one hot)
//   wb_stall                   downstream cannot take a writeback
//   wb_vld/wb_rd_idx/wb_data   registered writeback slot
//   wb_we                      register-file write enable (rd != x0)
//   scb_ret_reg_valid/idx      scoreboard retire strobe and index
// ---------------------------------------------------------------------------
module core_ctrl_wb_arb
  import core_ctrl_wb_arb_pkg::*;
#(
  parameter int NUM_REQ = core_ctrl_wb_arb_pkg::NUM_REQ,
  parameter int XLEN    = core_ctrl_wb_arb_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [5*NUM_REQ-1:0]    req_rd_idx,
  input  logic [XLEN*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_rdy,
  input  logic                    wb_stall,
  output logic                    wb_vld,
  output logic                    wb_we,
  output logic [4:0]              wb_rd_idx,
  output logic [XLEN-1:0]         wb_data,
  output logic                    scb_ret_reg_valid,
  output logic [4:0]              scb_ret_reg_idx
);

  localparam int PW = ptr_width(NUM_REQ);

  logic                 w_free;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_gnt_any;
  logic [PW-1:0]        w_ptr;
  logic [RD_W-1:0]      w_rd_chain   [NUM_REQ+1];
  logic [XLEN-1:0]      w_data_chain [NUM_REQ+1];

  logic                 r_wb_vld;
  logic [RD_W-1:0]      r_wb_rd;
  logic [XLEN-1:0]      r_wb_data;

  // Slot can accept when empty or when its current entry leaves this cycle.
  assign w_free = !r_wb_vld || !wb_stall;

  core_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req (req_vld),
    .ptr (w_ptr),
    .en  (w_free),
    .gnt (w_gnt)
  );

  assign req_rdy   = w_gnt;
  assign w_gnt_any = |w_gnt;

  // One-hot AND-OR select of the granted requester's payload.
  assign w_rd_chain[0]   = '0;
  assign w_data_chain[0] = '0;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
    assign w_rd_chain[g+1]   = w_rd_chain[g]
                             | (req_rd_idx[g*RD_W +: RD_W] & {RD_W{w_gnt[g]}});
    assign w_data_chain[g+1] = w_data_chain[g]
                             | (req_data[g*XLEN +: XLEN] & {XLEN{w_gnt[g]}});
  end

`ifdef CORE_WB_ARB_RR_EN
  logic [PW-1:0] w_idx_chain [NUM_REQ+1];
  logic [PW-1:0] r_rr_ptr;

  // Binary index of the granted requester.
  assign w_idx_chain[0] = '0;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_idx
    assign w_idx_chain[g+1] = w_gnt[g] ? PW'(g) : w_idx_chain[g];
  end

  // Pointer moves just past the winner so it drops to lowest priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= (w_idx_chain[NUM_REQ] == PW'(NUM_REQ - 1))
                ? '0 : w_idx_chain[NUM_REQ] + PW'(1);
    end
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  // Writeback slot register; data holds while stalled or idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wb_vld  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (w_free) begin
      r_wb_vld <= w_gnt_any;
      if (w_gnt_any) begin
        r_wb_rd   <= w_rd_chain[NUM_REQ];
        r_wb_data <= w_data_chain[NUM_REQ];
      end
    end
  end

  assign wb_vld            = r_wb_vld;
  assign wb_rd_idx         = r_wb_rd;
  assign wb_data           = r_wb_data;
  assign wb_we             = r_wb_vld && (r_wb_rd != '0);
  // x0 writebacks still retire so the scoreboard entry is released.
  assign scb_ret_reg_valid = r_wb_vld && !wb_stall;
  assign scb_ret_reg_idx   = r_wb_rd;

endmodule
